// File: rtl/pad_conv_pkg.sv
// Shared definitions for the padded 3x3 convolution front end: sequencer state
// encoding, window size and padded-frame size helper.
package pad_conv_pkg;

    localparam int K = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_NEXT   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    function automatic int PADDED(input int d);
        return (d + 2) * (d + 2);
    endfunction

endpackage

// File: rtl/pad_conv_sequencer_if.sv
// Pixel-path bundle between upstream source, padding engine and the window/MAC
// stage; master is the sequencer, slave is the surrounding datapath.
interface pad_conv_sequencer_if #(
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic          out_ready;
    logic          pad_clr;
    logic          pad_en;
    logic          out_valid;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          win_valid;

    modport master (
        input  in_valid, out_ready,
        output in_ready, pad_clr, pad_en, out_valid, out_row, out_col, win_valid
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, pad_clr, pad_en, out_valid, out_row, out_col, win_valid
    );
endinterface

// File: rtl/pad_coord_counter.sv
// Row/column tracker for a (D+2)x(D+2) padded raster; flags positions where a
// full KxK window ending at the current pixel exists.
module pad_coord_counter
    import pad_conv_pkg::*;
#(
    parameter int D  = 220,
    parameter int CW = $clog2(D + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          valid_i,
    output logic [CW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          win_valid_o
);

    localparam logic [CW-1:0] LAST    = CW'(D + 1);
    localparam logic [CW-1:0] WIN_MIN = CW'(K - 1);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o       = row_q;
    assign col_o       = col_q;
    assign win_valid_o = valid_i && (row_q >= WIN_MIN) && (col_q >= WIN_MIN);

endmodule

// File: rtl/pad_conv_sequencer.sv
// Sequences the zero-padding engine per channel: clear, load D*D pixels, then
// stream the padded frame tagged with coordinates and window-valid flags.
module pad_conv_sequencer
    import pad_conv_pkg::*;
#(
    parameter int D      = 220,
    parameter int NUM_CH = 3,
    parameter int CW     = $clog2(D + 2),
    parameter int LW     = $clog2(D * D + 1),
    parameter int SW     = $clog2((D + 2) * (D + 2) + 2),
    parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    pad_conv_sequencer_if.master   bus,
    output logic [CHW-1:0]         ch_idx,
    output logic                   busy,
    output logic                   done
);

    localparam logic [LW-1:0]  LOAD_LAST   = LW'(D * D - 1);
    localparam logic [LW-1:0]  LOAD_MAX    = LW'(D * D);
    localparam logic [SW-1:0]  STREAM_LAST = SW'(PADDED(D));
    localparam logic [SW-1:0]  STREAM_MAX  = SW'(PADDED(D) + 1);
    localparam logic [CHW-1:0] CH_LAST     = CHW'(NUM_CH - 1);

    logic [2:0]     state_q, state_d;
    logic [CHW-1:0] ch_idx_q, ch_idx_d;
    logic           abort_pend_q, abort_pend_d;
    logic [LW-1:0]  load_cnt_q, load_cnt_d;
    logic [SW-1:0]  stream_cnt_q, stream_cnt_d;
    logic           out_valid_q, out_valid_d;
    logic           accept, step;
    logic [CW-1:0]  row, col;
    logic           win_valid;

    assign accept = (state_q == ST_LOAD) && bus.in_valid;
    assign step   = (state_q == ST_STREAM) && bus.out_ready;

    always_comb begin
        state_d      = state_q;
        ch_idx_d     = ch_idx_q;
        abort_pend_d = abort_pend_q;
        load_cnt_d   = load_cnt_q;
        stream_cnt_d = stream_cnt_q;

        if (abort && (state_q != ST_IDLE)) begin
            // Route through CLEAR so the engine is left empty, then drop to IDLE.
            state_d      = ST_CLEAR;
            abort_pend_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d      = ST_CLEAR;
                        ch_idx_d     = '0;
                        abort_pend_d = 1'b0;
                    end
                end
                ST_CLEAR: begin
                    load_cnt_d   = '0;
                    stream_cnt_d = '0;
                    abort_pend_d = 1'b0;
                    state_d      = abort_pend_q ? ST_IDLE : ST_LOAD;
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (load_cnt_q != LOAD_MAX) load_cnt_d = load_cnt_q + 1'b1;
                        if (load_cnt_q == LOAD_LAST) state_d = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (step) begin
                        if (stream_cnt_q != STREAM_MAX) stream_cnt_d = stream_cnt_q + 1'b1;
                        if (stream_cnt_q == STREAM_LAST) state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (ch_idx_q == CH_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        ch_idx_d = ch_idx_q + 1'b1;
                        state_d  = ST_CLEAR;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Step 0 only primes the engine pipeline; its output slot carries no pixel.
    assign out_valid_d = step && (stream_cnt_q != '0) && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ch_idx_q     <= '0;
            abort_pend_q <= 1'b0;
            load_cnt_q   <= '0;
            stream_cnt_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_idx_q     <= ch_idx_d;
            abort_pend_q <= abort_pend_d;
            load_cnt_q   <= load_cnt_d;
            stream_cnt_q <= stream_cnt_d;
            out_valid_q  <= out_valid_d;
        end
    end

    pad_coord_counter #(
        .D  (D),
        .CW (CW)
    ) u_coord (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (state_q == ST_CLEAR),
        .en_i        (out_valid_q),
        .valid_i     (out_valid_q),
        .row_o       (row),
        .col_o       (col),
        .win_valid_o (win_valid)
    );

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.pad_clr   = (state_q == ST_CLEAR);
    assign bus.pad_en    = (state_q == ST_LOAD)   ? bus.in_valid  :
                           (state_q == ST_STREAM) ? bus.out_ready : 1'b0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = row;
    assign bus.out_col   = col;
    assign bus.win_valid = win_valid;

    assign ch_idx = ch_idx_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_pad_conv_sequencer.sv
// Scoreboard bench for pad_conv_sequencer at D=4, NUM_CH=2: a raster model of
// every padded pixel per channel is queued on start and popped by a monitor.
module tb_pad_conv_sequencer;

    localparam int D      = 4;
    localparam int NUM_CH = 2;
    localparam int CW     = $clog2(D + 2);
    localparam int NPAD   = (D + 2) * (D + 2);

    typedef struct {
        int ch;
        int row;
        int col;
        int win;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [0:0] ch_idx;
    logic       busy;
    logic       done;

    pad_conv_sequencer_if #(.CW(CW)) bus ();

    pad_conv_sequencer #(
        .D      (D),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .bus    (bus),
        .ch_idx (ch_idx),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    pix_t sb[$];
    int   n_clr, n_load, n_stream, n_ov, n_win, n_done;
    int   ch_load = 0, ch_stream = 0;
    bit   load_phase = 0, abort_clr = 0, bp_armed = 0;
    int   stall_idx = 0;
    int   iv_pct = 100, or_pct = 100;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each channel emits the full padded raster in row-major order.
    task automatic push_expected();
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int r = 0; r < D + 2; r++)
                for (int c = 0; c < D + 2; c++)
                    sb.push_back('{ch, r, c, (r >= 2 && c >= 2) ? 1 : 0});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Input driver: random valid/ready, plus a one-shot 5-cycle stall at (3,1).
    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.in_valid = ($urandom_range(99) < iv_pct);
            if (bp_armed && bus.out_valid && bus.out_row == 3 && bus.out_col == 1) begin
                bp_armed      = 0;
                stall_idx     = 1;
                bus.out_ready = 1'b0;
            end else if (stall_idx > 0 && stall_idx < 5) begin
                stall_idx++;
                bus.out_ready = 1'b0;
            end else begin
                stall_idx     = 0;
                bus.out_ready = ($urandom_range(99) < or_pct);
            end
        end
    end

    // Monitor: event counting, per-cycle protocol checks and scoreboard pops.
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                load_phase = 0;
            end else begin
                if (load_phase) begin
                    check("in_ready_in_load", bus.in_ready, 1);
                    check("load_pad_en", bus.pad_en, bus.in_valid);
                end
                if (bus.pad_en) begin
                    if (bus.in_ready) begin
                        n_load++;
                        ch_load++;
                        if (ch_load == D * D) load_phase = 0;
                    end else begin
                        if (ch_stream == 0) check("loads_before_stream", ch_load, D * D);
                        n_stream++;
                        ch_stream++;
                    end
                end
                if (stall_idx > 0) check("stall_pad_en", bus.pad_en, 0);
                if (stall_idx > 1) begin
                    check("stall_out_valid", bus.out_valid, 0);
                    check("stall_row", bus.out_row, 3);
                    check("stall_col", bus.out_col, 2);
                end
                if (done) n_done++;
                if (bus.out_valid) begin
                    n_ov++;
                    if (bus.win_valid) n_win++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pixel_unexpected: got ch%0d r%0d c%0d with nothing expected at %0t",
                                 ch_idx, bus.out_row, bus.out_col, $time);
                    end else begin
                        e = sb.pop_front();
                        check("pixel(ch*1000+row*100+col*10+win)",
                              int'(ch_idx) * 1000 + int'(bus.out_row) * 100 +
                              int'(bus.out_col) * 10 + int'(bus.win_valid),
                              e.ch * 1000 + e.row * 100 + e.col * 10 + e.win);
                    end
                end else begin
                    check("win_without_valid", bus.win_valid, 0);
                end
                if (bus.pad_clr) begin
                    n_clr++;
                    ch_load    = 0;
                    ch_stream  = 0;
                    load_phase = !abort_clr;
                end
            end
        end
    end

    task automatic run_job(input int ivp, input int orp, input bit bp, input bit restart);
        int cyc = 0;
        iv_pct   = ivp;
        or_pct   = orp;
        bp_armed = bp;
        n_clr = 0; n_load = 0; n_stream = 0; n_ov = 0; n_win = 0; n_done = 0;
        push_expected();
        pulse_start();
        if (restart) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        while (n_done == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("job_done_seen", n_done, 1);
        check("busy_after_done", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("job_pad_clr", n_clr, NUM_CH);
        check("job_loads", n_load, NUM_CH * D * D);
        check("job_stream_steps", n_stream, NUM_CH * (NPAD + 1));
        check("job_out_valid", n_ov, NUM_CH * NPAD);
        check("job_win_valid", n_win, NUM_CH * D * D);
        check("job_done_once", n_done, 1);
        check("job_sb_drained", sb.size(), 0);
        check("job_ch_idx_hold", ch_idx, NUM_CH - 1);
        if (bp) check("stall_triggered", bp_armed, 0);
        bp_armed = 0;
        sb.delete();
    endtask

    task automatic do_abort();
        int cyc = 0;
        iv_pct = 70;
        or_pct = 70;
        n_done = 0;
        push_expected();
        pulse_start();
        while (!(ch_idx == 1 && ch_stream == 10) && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_point_reached", (ch_idx == 1 && ch_stream == 10) ? 1 : 0, 1);
        abort     = 1'b1;
        abort_clr = 1;
        @(posedge clk); #1 abort = 1'b0;
        sb.delete();
        check("abort_clr_pulse", bus.pad_clr, 1);
        check("abort_busy_in_clear", busy, 1);
        @(posedge clk); #1;
        check("abort_idle", busy, 0);
        check("abort_clr_single", bus.pad_clr, 0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", n_done, 0);
        abort_clr = 0;
    endtask

    task automatic do_reset_mid_load();
        int cyc = 0;
        iv_pct = 50;
        or_pct = 100;
        push_expected();
        pulse_start();
        while (!(ch_idx == 1 && ch_load >= 5 && ch_load < D * D) && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reset_point_reached", (ch_idx == 1 && ch_load >= 5) ? 1 : 0, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ch_idx", ch_idx, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_pad_en", bus.pad_en, 0);
        check("rst_pad_clr", bus.pad_clr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_win_valid", bus.win_valid, 0);
        check("rst_out_row", bus.out_row, 0);
        check("rst_out_col", bus.out_col, 0);
        @(posedge clk); #1 reset = 1'b0;
        sb.delete();
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_reset", busy, 0);
    endtask

    initial begin
        #3;
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_in_ready", bus.in_ready, 0);
        check("init_pad_en", bus.pad_en, 0);
        check("init_pad_clr", bus.pad_clr, 0);
        check("init_out_valid", bus.out_valid, 0);
        check("init_out_row", bus.out_row, 0);
        check("init_out_col", bus.out_col, 0);
        check("init_ch_idx", ch_idx, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_job(100, 100, 0, 1);
        run_job(50, 100, 0, 0);
        run_job(80, 80, 1, 0);
        run_job(60, 60, 0, 0);
        do_abort();
        run_job(70, 70, 0, 0);
        do_reset_mid_load();
        run_job(60, 60, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pad_conv_sequencer.md
Name: pad_conv_sequencer

Overview:
Controller that sequences the 3x3 zero-padding engine over a multi-channel frame.
- Per channel: clears the engine, loads D*D pixels from the upstream stream, then streams the (D+2)x(D+2) padded frame.
- Tags each padded pixel with row/col coordinates and flags positions where a full 3x3 window exists.
- Sits between the pixel source / padding engine and the downstream window / MAC stage.

Parameters:
D, 220, unpadded frame width = height in pixels
NUM_CH, 3, input channels processed per start
CW, $clog2(D+2), width of out_row/out_col
LW, $clog2(D*D+1), width of the load counter
SW, $clog2((D+2)*(D+2)+2), width of the stream counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  1-cycle request to process NUM_CH channels
abort  in  1  synchronous abort of the current job
in_valid  in  1  upstream pixel present
in_ready  out  1  controller accepts upstream pixel
out_ready  in  1  downstream can take a padded pixel
pad_clr  out  1  synchronous clear pulse to padding engine
pad_en  out  1  enable to padding engine (load or stream step)
out_valid  out  1  engine output this cycle is a real padded pixel
out_row  out  CW  padded row of current output, 0..D+1
out_col  out  CW  padded column of current output, 0..D+1
win_valid  out  1  out_valid and out_row>=2 and out_col>=2
ch_idx  out  $clog2(NUM_CH)  channel being processed (min width 1)
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse when the last channel completes

Behaviour:
- Reset (asynchronous, active-high; clock clk): state=IDLE; all outputs 0; all counters 0.
- States: IDLE, CLEAR, LOAD, STREAM, NEXT, DONE.
- IDLE:
  - start=1 -> CLEAR; ch_idx=0.
  - start is ignored in every other state.
- CLEAR:
  - pad_clr=1 for exactly 1 cycle.
  - load_cnt, stream_cnt, out_row, out_col cleared.
  - -> LOAD.
- LOAD:
  - in_ready=1; pad_en = in_valid & in_ready.
  - load_cnt increments on each accepted pixel.
  - On acceptance of pixel number D*D (load_cnt == D*D-1 and accept) -> STREAM next cycle.
  - in_ready=0 outside LOAD.
- STREAM:
  - pad_en = out_ready.
  - stream_cnt increments on each pad_en; exactly (D+2)^2+1 enabled cycles are issued.
  - Engine output is registered, one cycle after each enabled step.
  - The first step is a priming step: its result is dropped (out_valid=0, coordinates not advanced).
  - out_valid is registered: 1 the cycle after each non-priming pad_en in STREAM, else 0.
  - out_row/out_col describe the pixel carried while out_valid=1.
  - On each out_valid, advance col; at D+1 wrap col to 0 and increment row.
  - When out_ready=0: pad_en=0, engine holds, out_valid=0 next cycle, counters frozen.
  - After the final enabled step -> NEXT; the last out_valid is asserted in the NEXT cycle.
- NEXT (1 cycle):
  - ch_idx==NUM_CH-1 -> DONE.
  - Otherwise increment ch_idx -> CLEAR.
- DONE: done=1 for 1 cycle -> IDLE. ch_idx holds its last value until the next start.
- abort=1 in any non-IDLE state: next state CLEAR with a forced return to IDLE afterwards (engine left clean), no done pulse.
- abort has priority over all other transitions. abort in IDLE has no effect.
- Per channel:
  - out_valid asserted exactly (D+2)^2 times.
  - win_valid asserted exactly D*D times.
- Counters never wrap: load_cnt saturates at D*D, stream_cnt at (D+2)^2+1.

Decomposition:
- Shared package pad_conv_pkg:
  - state encoding (localparam enum: IDLE..DONE)
  - padded-size constant function PADDED(D) = (D+2)*(D+2)
  - window size constant K=3
- One natural sub-module: pad_coord_counter (row/col counter with wrap at D+1, enable, clear, and win_valid compare), reused by downstream window logic.

Test Plan (D=4, NUM_CH=2 unless noted):
- Basic: start, in_valid=1 continuous, out_ready=1 -> per channel: pad_clr 1 cycle, 16 loads, 37 pad_en cycles, 36 out_valid, 16 win_valid (rows/cols 2..5); done once after channel 1; busy low next cycle.
- Upstream gaps: in_valid toggling 1/0 -> still exactly 16 pad_en in LOAD; in_ready high throughout LOAD; STREAM entered only after 16th accept.
- Backpressure: out_ready=0 for 5 cycles at out_row=3,out_col=1 -> no pad_en, out_valid=0, coordinates frozen; resume yields out_col=2 next with a 36 total count.
- Coordinate order: first out_valid has row=0,col=0; col 5 -> col 0/row+1; last out_valid row=5,col=5; first win_valid at row=2,col=2.
- Abort mid-STREAM (ch_idx=1, stream_cnt=10) -> pad_clr pulse next cycle, then IDLE, no done; new start runs cleanly from ch_idx=0.
- Async reset asserted mid-LOAD -> all outputs 0 immediately, state IDLE; start while busy=1 ignored (no restart, counts unchanged).
